// File: rtl/paddle_ctrl.sv
// Paddle game controller: synchronizes and debounces the three buttons, paces
// paddle moves with a tick divider, and sequences IDLE/PLAY/PAUSED/OVER.
module paddle_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int PADDLE_W  = 64,
  parameter int TICK_DIV  = 250000,
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_pause,
  input  logic       game_over,
  input  logic [9:0] x_pos,
  output logic       move_left,
  output logic       move_right,
  output logic       pause,
  output logic       load_init,
  output logic       start_out,
  output logic [1:0] state
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [10:0] X_MAX = 11'(SCREEN_W - PADDLE_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

  // Button vectors: bit 0 = left, bit 1 = right, bit 2 = pause.
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      db_q, db_d;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];
  logic            pause_prev_q;
  logic            pause_edge;

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  state_e state_q, state_d;
  logic   move_left_q, move_left_d;
  logic   move_right_q, move_right_d;
  logic   pause_q, load_init_q, start_out_q;

  // A level is accepted only after DB_CYCLES consecutive cycles that differ
  // from the current debounced value; any return to it restarts the count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign pause_edge = db_q[2] & ~pause_prev_q;
  assign tick       = (state_q == ST_PLAY) && (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  always_comb begin
    tick_cnt_d = '0;
    if (state_q == ST_PLAY && !tick) tick_cnt_d = tick_cnt_q + TICK_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    move_left_d  = 1'b0;
    move_right_d = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (db_q[0] || db_q[1]) state_d = ST_PLAY;
      ST_PLAY: begin
        if (game_over) begin
          state_d = ST_OVER;
        end else if (pause_edge) begin
          state_d = ST_PAUSED;
        end else if (tick) begin
          move_left_d  = db_q[0] && !db_q[1] && (x_pos != 10'd0);
          move_right_d = db_q[1] && !db_q[0] && ({1'b0, x_pos} < X_MAX);
        end
      end
      ST_PAUSED: begin
        if (game_over)       state_d = ST_OVER;
        else if (pause_edge) state_d = ST_PLAY;
      end
      ST_OVER:   if (pause_edge) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      pause_prev_q <= 1'b0;
      tick_cnt_q   <= '0;
      state_q      <= ST_IDLE;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      pause_q      <= 1'b0;
      load_init_q  <= 1'b1;
      start_out_q  <= 1'b1;
    end else begin
      sync1_q      <= {btn_pause, btn_right, btn_left};
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      pause_prev_q <= db_q[2];
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
      pause_q      <= (state_d == ST_PAUSED) || (state_d == ST_OVER);
      load_init_q  <= (state_d == ST_IDLE);
      start_out_q  <= (state_d == ST_IDLE);
    end
  end

  assign move_left  = move_left_q;
  assign move_right = move_right_q;
  assign pause      = pause_q;
  assign load_init  = load_init_q;
  assign start_out  = start_out_q;
  assign state      = state_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with TICK_DIV=4 and DB_CYCLES=2; all driving
// and sampling happens on the falling clock edge.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_left, btn_right, btn_pause, game_over;
  logic [9:0] x_pos;
  logic       move_left, move_right, pause, load_init, start_out;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  paddle_ctrl #(
    .SCREEN_W (640),
    .PADDLE_W (64),
    .TICK_DIV (4),
    .DB_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_pause (btn_pause),
    .game_over (game_over),
    .x_pos     (x_pos),
    .move_left (move_left),
    .move_right(move_right),
    .pause     (pause),
    .load_init (load_init),
    .start_out (start_out),
    .state     (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Samples the move outputs for n cycles.
  task automatic count_moves(input int n, output int nl, output int nr, output int nboth);
    nl = 0; nr = 0; nboth = 0;
    repeat (n) begin
      @(negedge clk);
      if (move_left)              nl++;
      if (move_right)             nr++;
      if (move_left && move_right) nboth++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_start"}, start_out, 1);
    check({tag, "_load"},  load_init, 1);
    check({tag, "_pause"}, pause, 0);
    check({tag, "_ml"},    move_left, 0);
    check({tag, "_mr"},    move_right, 0);
  endtask

  initial begin
    int nl, nr, nb;
    reset = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_pause = 1'b0;
    game_over = 1'b0; x_pos = 10'd288;
    cyc(2);
    check_reset_outputs("rst");
    check("rst_tick", dut.tick_cnt_q, 0);
    check("rst_db",   dut.db_q, 0);

    // Right held from reset release: 2 sync + 2 debounce cycles, then PLAY.
    reset = 1'b1; btn_right = 1'b1;
    cyc(4); check("idle_before_db", state, 0);
    cyc(1); check("enter_play", state, 1);
    check("play_start", start_out, 0);
    check("play_load", load_init, 0);
    check("no_pulse_on_entry", move_right, 0);
    cyc(3); check("mr_before_tick", move_right, 0);
    cyc(1); check("mr_first_pulse", move_right, 1);
    cyc(1); check("mr_one_cycle", move_right, 0);
    count_moves(16, nl, nr, nb);
    check("mr_288_count", nr, 4);
    check("ml_288_count", nl, 0);

    x_pos = 10'd576;
    count_moves(16, nl, nr, nb);
    check("mr_576_count", nr, 0);
    x_pos = 10'd575;
    count_moves(16, nl, nr, nb);
    check("mr_575_count", nr, 4);

    btn_right = 1'b0; btn_left = 1'b1; x_pos = 10'd0;
    cyc(8);
    count_moves(16, nl, nr, nb);
    check("ml_x0_count", nl, 0);
    check("mr_x0_count", nr, 0);
    x_pos = 10'd1;
    count_moves(16, nl, nr, nb);
    check("ml_x1_count", nl, 4);
    check("mr_x1_count", nr, 0);

    btn_right = 1'b1; x_pos = 10'd300;
    cyc(8);
    count_moves(40, nl, nr, nb);
    check("both_ml", nl, 0);
    check("both_mr", nr, 0);
    check("both_same_cycle", nb, 0);

    // Pause with only left held.
    btn_right = 1'b0; x_pos = 10'd100;
    cyc(8);
    btn_pause = 1'b1;
    cyc(5); check("paused_state", state, 2);
    check("paused_pause", pause, 1);
    cyc(1); check("paused_tick_clr", dut.tick_cnt_q, 0);
    btn_pause = 1'b0;
    count_moves(16, nl, nr, nb);
    check("paused_no_ml", nl, 0);
    btn_pause = 1'b1;
    cyc(5); check("resume_state", state, 1);
    check("resume_pause", pause, 0);
    btn_pause = 1'b0;
    cyc(6);

    // Back to PAUSED, then game_over together with pause_edge.
    btn_pause = 1'b1;
    cyc(5); check("paused2_state", state, 2);
    btn_pause = 1'b0; cyc(6);
    btn_left = 1'b0; cyc(6);
    btn_pause = 1'b1;
    cyc(4); game_over = 1'b1;
    cyc(1); game_over = 1'b0;
    check("over_priority", state, 3);
    check("over_pause", pause, 1);
    btn_pause = 1'b0; cyc(6);
    game_over = 1'b1; cyc(1); game_over = 1'b0; cyc(1);
    check("over_ignores_go", state, 3);
    btn_pause = 1'b1;
    cyc(5); check("restart_state", state, 0);
    check("restart_load", load_init, 1);
    check("restart_start", start_out, 1);
    check("restart_pause", pause, 0);
    btn_pause = 1'b0; cyc(6);

    // One-cycle glitches on left never reach the debounced level.
    for (int i = 0; i < 5; i++) begin
      btn_left = 1'b1; cyc(1);
      btn_left = 1'b0; cyc(2);
    end
    cyc(4);
    check("glitch_db_left", dut.db_q[0], 0);
    check("glitch_state", state, 0);

    // Reset asserted while a move pulse is out.
    btn_right = 1'b1; x_pos = 10'd288;
    cyc(5); check("replay_state", state, 1);
    cyc(4); check("replay_pulse", move_right, 1);
    reset = 1'b0; #1;
    check_reset_outputs("async_rst");
    check("async_rst_db", dut.db_q, 0);
    cyc(3);
    check("held_rst_mr", move_right, 0);
    check("held_rst_state", state, 0);

    // PLAY -> OVER on game_over, no moves afterwards.
    reset = 1'b1;
    cyc(5); check("play3_state", state, 1);
    game_over = 1'b1; cyc(1); game_over = 1'b0;
    check("play_to_over", state, 3);
    count_moves(16, nl, nr, nb);
    check("over_no_mr", nr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
